// File: rtl/range_sensor_scheduler.sv
// range_sensor_scheduler
// Round-robin ping sequencer for two ultrasonic range sensors. Only one
// sensor is active at a time: trigger, wait for the echo to rise, measure
// the echo high time in clk cycles, then settle before the other channel
// fires. Each channel's last good echo width is held on dist0_o / dist1_o.
module range_sensor_scheduler #(
    parameter int COUNT_W        = 21,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int SETTLE_CYCLES  = 500000
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic [1:0]         echo_i,
    output logic [1:0]         trig_o,
    output logic [COUNT_W-1:0] dist0_o,
    output logic [COUNT_W-1:0] dist1_o,
    output logic [1:0]         valid_o,
    output logic [1:0]         timeout_o,
    output logic               busy_o
);

    // Terminal counts; each phase ends on the cycle the shared counter
    // holds its last value, so a phase lasts exactly N cycles from entry.
    localparam logic [COUNT_W-1:0] TRIG_LAST    = COUNT_W'(TRIG_CYCLES - 1);
    localparam logic [COUNT_W-1:0] TIMEOUT_LAST = COUNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_W-1:0] SETTLE_LAST  = COUNT_W'(SETTLE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_ZERO     = '0;
    localparam logic [COUNT_W-1:0] CNT_ONE      = COUNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_SETTLE    = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               ch_q, ch_d;
    logic [1:0]         valid_q, valid_d;
    logic [1:0]         timeout_q, timeout_d;
    logic [COUNT_W-1:0] dist0_q, dist1_q;
    logic               dist_ld;

    // Echo synchroniser (two flops) followed by an edge-detect register.
    logic [1:0] sync1_q, sync2_q, echo_prev_q;

    // Per-channel views of the active sensor only; the idle sensor's echo
    // never reaches the FSM, so stray echoes cannot start a measurement.
    logic       echo_s;
    logic       echo_rise;
    logic [1:0] ch_oh;

    assign echo_s    = sync2_q[ch_q];
    assign echo_rise = sync2_q[ch_q] & ~echo_prev_q[ch_q];
    assign ch_oh     = ch_q ? 2'b10 : 2'b01;

    // Bring the asynchronous echo lines into the clk domain and keep the
    // previous synced value for edge detection.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q     <= 2'b00;
            sync2_q     <= 2'b00;
            echo_prev_q <= 2'b00;
        end else begin
            sync1_q     <= echo_i;
            sync2_q     <= sync1_q;
            echo_prev_q <= sync2_q;
        end
    end

    // State register together with the shared counter, channel pointer
    // and the registered result strobes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ch_q      <= 1'b0;
            valid_q   <= 2'b00;
            timeout_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    // Distance holding registers; they move only when a ping completes
    // with a clean falling edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dist0_q <= '0;
            dist1_q <= '0;
        end else if (dist_ld) begin
            if (ch_q) dist1_q <= cnt_q;
            else      dist0_q <= cnt_q;
        end
    end

    // Next-state logic: phase sequencing, counter update and strobe
    // generation. The counter restarts on every phase change.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_ONE;
        ch_d      = ch_q;
        valid_d   = 2'b00;
        timeout_d = 2'b00;
        dist_ld   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = CNT_ZERO;
                if (enable_i) state_d = S_TRIG;
            end
            S_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = S_WAIT_RISE;
                    cnt_d   = CNT_ZERO;
                end
            end
            S_WAIT_RISE: begin
                // The rising cycle is itself the first high cycle of the
                // echo, so the measurement starts at 1, not 0.
                if (echo_rise) begin
                    state_d = S_MEASURE;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = S_SETTLE;
                    cnt_d     = CNT_ZERO;
                    timeout_d = ch_oh;
                end
            end
            S_MEASURE: begin
                // Entered on a synced high, so a synced low here is the
                // falling edge. Both edges see the same sync delay.
                if (!echo_s) begin
                    state_d = S_SETTLE;
                    cnt_d   = CNT_ZERO;
                    dist_ld = 1'b1;
                    valid_d = ch_oh;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // One more high cycle would make the width reach the
                    // limit: abandon the ping and keep the old distance.
                    state_d   = S_SETTLE;
                    cnt_d     = CNT_ZERO;
                    timeout_d = ch_oh;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    ch_d    = ~ch_q;
                    cnt_d   = CNT_ZERO;
                    state_d = enable_i ? S_TRIG : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Moore outputs decoded from the registered state, so trig_o falls
    // the instant reset asserts.
    always_comb begin
        trig_o = 2'b00;
        busy_o = 1'b1;
        unique case (state_q)
            S_IDLE:  busy_o = 1'b0;
            S_TRIG:  trig_o = ch_oh;
            default: ;
        endcase
    end

    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;
    assign dist0_o   = dist0_q;
    assign dist1_o   = dist1_q;

endmodule

// File: tb/tb_range_sensor_scheduler.sv
// tb_range_sensor_scheduler
// Directed walk through reset, a clean ch0 ping, a ch1 rise timeout, a ch0
// width timeout, cross-channel echo rejection with enable dropped mid-ping,
// and an asynchronous reset during a trigger pulse.
module tb_range_sensor_scheduler;

    localparam int COUNT_W        = 8;
    localparam int TRIG_CYCLES    = 4;
    localparam int TIMEOUT_CYCLES = 100;
    localparam int SETTLE_CYCLES  = 10;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [1:0]         echo;
    logic [1:0]         trig_o;
    logic [COUNT_W-1:0] dist0_o, dist1_o;
    logic [1:0]         valid_o, timeout_o;
    logic               busy_o;

    int   passes = 0;
    int   fails  = 0;
    int   total  = 0;
    logic [1:0] valid_acc;
    logic       bad;

    range_sensor_scheduler #(
        .COUNT_W        (COUNT_W),
        .TRIG_CYCLES    (TRIG_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SETTLE_CYCLES  (SETTLE_CYCLES)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .enable_i  (enable),
        .echo_i    (echo),
        .trig_o    (trig_o),
        .dist0_o   (dist0_o),
        .dist1_o   (dist1_o),
        .valid_o   (valid_o),
        .timeout_o (timeout_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and record exclusivity violations.
    task automatic tick;
        @(negedge clk);
        valid_acc = valid_acc | valid_o;
        if ((valid_o & timeout_o) != 2'b00 || trig_o == 2'b11 ||
            valid_o == 2'b11 || timeout_o == 2'b11)
            bad = 1'b1;
    endtask

    initial begin
        int k;
        int n;
        int first;
        logic [1:0] tv;
        logic idle_bad;

        reset = 1'b1; enable = 1'b0; echo = 2'b00;
        valid_acc = 2'b00; bad = 1'b0;

        // 1: reset held, echo toggling
        for (int i = 0; i < 8; i++) begin
            echo = 2'(i);
            tick;
            check("rst_outputs", {trig_o, valid_o, timeout_o, busy_o, dist0_o, dist1_o}, 0);
        end
        echo = 2'b00;
        tick;
        reset = 1'b0;
        tick; tick;
        check("idle_busy", busy_o, 0);
        check("idle_trig", trig_o, 0);

        // 2: clean ch0 ping of 37 cycles
        enable = 1'b1;
        k = 0; while (trig_o == 2'b00 && k < 20) begin tick; k++; end
        check("t2_trig_ch0", trig_o, 2'b01);
        n = 0; while (trig_o == 2'b01 && n < 50) begin n++; tick; end
        check("t2_trig_len", n, 4);
        repeat (20) tick;
        echo[0] = 1'b1;
        repeat (37) tick;
        echo[0] = 1'b0;
        k = 0; while (valid_o == 2'b00 && k < 20) begin tick; k++; end
        check("t2_valid_lat", k, 3);
        check("t2_valid", valid_o, 2'b01);
        check("t2_dist0", dist0_o, 37);
        check("t2_no_tmo", timeout_o, 0);
        tick;
        check("t2_valid_1cyc", valid_o, 0);
        k = 1; while (trig_o == 2'b00 && k < 50) begin tick; k++; end
        check("t2_settle_gap", k, 10);
        check("t3_trig_ch1", trig_o, 2'b10);

        // 3: ch1 echo never rises
        valid_acc = 2'b00;
        n = 0; while (trig_o == 2'b10 && n < 50) begin n++; tick; end
        check("t3_trig_len", n, 4);
        k = 0; while (timeout_o == 2'b00 && k < 200) begin tick; k++; end
        check("t3_tmo_delay", k, 100);
        check("t3_tmo", timeout_o, 2'b10);
        check("t3_no_valid", valid_acc, 0);
        check("t3_dist1", dist1_o, 0);
        tick;
        check("t3_tmo_1cyc", timeout_o, 0);
        k = 1; while (trig_o == 2'b00 && k < 50) begin tick; k++; end
        check("t3_settle_gap", k, 10);
        check("t4_trig_ch0", trig_o, 2'b01);

        // 4: ch0 echo stuck high for 150 cycles
        n = 0; while (trig_o == 2'b01 && n < 50) begin n++; tick; end
        check("t4_trig_len", n, 4);
        valid_acc = 2'b00;
        echo[0] = 1'b1;
        first = 0; tv = 2'b00;
        for (int i = 1; i <= 150; i++) begin
            tick;
            if (timeout_o != 2'b00 && first == 0) begin
                first = i;
                tv    = timeout_o;
            end
        end
        check("t4_tmo_time", first, 102);
        check("t4_tmo", tv, 2'b01);
        check("t4_no_valid", valid_acc, 0);
        check("t4_dist0_kept", dist0_o, 37);
        // ch1 is now waiting; it must ignore the still-high ch0 line
        echo[0] = 1'b0;
        repeat (10) tick;
        echo[1] = 1'b1;
        repeat (25) tick;
        echo[1] = 1'b0;
        k = 0; while (valid_o == 2'b00 && k < 20) begin tick; k++; end
        check("t4_valid_ch1", valid_o, 2'b10);
        check("t4_dist1", dist1_o, 25);
        check("t4_dist0_hold", dist0_o, 37);

        // 5: foreign ch1 pulses, enable dropped mid-measure
        k = 0; while (trig_o == 2'b00 && k < 30) begin tick; k++; end
        check("t5_trig_ch0", trig_o, 2'b01);
        n = 0; while (trig_o == 2'b01 && n < 50) begin n++; tick; end
        echo[1] = 1'b1;
        repeat (5) tick;
        echo[1] = 1'b0;
        repeat (3) tick;
        echo[0] = 1'b1;
        repeat (10) tick;
        enable  = 1'b0;
        echo[1] = 1'b1;
        repeat (10) tick;
        echo[1] = 1'b0;
        repeat (30) tick;
        echo[0] = 1'b0;
        k = 0; while (valid_o == 2'b00 && k < 20) begin tick; k++; end
        check("t5_valid", valid_o, 2'b01);
        check("t5_dist0", dist0_o, 50);
        check("t5_dist1_hold", dist1_o, 25);
        k = 0; while (busy_o && k < 40) begin tick; k++; end
        check("t5_settle_to_idle", k, 10);
        idle_bad = 1'b0;
        repeat (20) begin
            tick;
            if (trig_o != 2'b00 || busy_o) idle_bad = 1'b1;
        end
        check("t5_stays_idle", idle_bad, 0);
        check("t5_dist0_hold", dist0_o, 50);

        // 6: reset pulsed in the middle of a ch1 trigger
        enable = 1'b1;
        k = 0; while (trig_o == 2'b00 && k < 20) begin tick; k++; end
        check("t6_trig_ch1", trig_o, 2'b10);
        tick;
        #2 reset = 1'b1;
        #1;
        check("t6_async_trig", trig_o, 0);
        check("t6_async_busy", busy_o, 0);
        check("t6_async_dist", {dist0_o, dist1_o}, 0);
        tick; tick;
        reset = 1'b0;
        k = 0; while (trig_o == 2'b00 && k < 20) begin tick; k++; end
        check("t6_restart_ch0", trig_o, 2'b01);
        n = 0; while (trig_o == 2'b01 && n < 50) begin n++; tick; end
        check("t6_trig_len", n, 4);

        check("exclusive_strobes", bad, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
